// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined block-cipher controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] EMPTY_ID     = 4'hF;
  localparam logic [3:0] MAX_ID       = 4'd4;
  localparam logic [3:0] DEF_RND_INIT = 4'd1;
  localparam logic [3:0] DEF_LAST_RND = 4'd10;

  function automatic logic is_live_id(input logic [3:0] id);
    return (id != 4'd0) && (id <= MAX_ID);
  endfunction

endpackage

// File: rtl/pipe_ctrl_stats.sv
// Saturating block / stall statistics counters, synchronously cleared while the controller is in INIT.
module pipe_ctrl_stats #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             blk_inc,
  input  logic             stall_inc,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt   <= '0;
      stall_cnt <= '0;
    end else if (clr) begin
      blk_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (blk_inc && (blk_cnt != '1))
        blk_cnt <= blk_cnt + 1'b1;
      if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Slot/round controller for a 4-deep round-recirculating cipher datapath.
// Optional statistics counters are built when PIPE_CTRL_STATS_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [3:0]  RND_INIT = DEF_RND_INIT,
  parameter logic [3:0]  LAST_RND = DEF_LAST_RND,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  output logic [3:0]       out_id,
  output logic             busy,
  input  logic             track_avlbl,
  input  logic             cmplt_sts,
  input  logic [3:0]       cur_mc2ark3_val,
  input  logic [3:0]       cur_mc2ark4_val,
  input  logic [3:0]       cur_ark2sb4_val,
  output logic             compute,
  output logic             do_load,
  output logic             init,
  output logic             add_track,
  output logic             sub_track,
  output logic [3:0]       rnd,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e state_q, state_d;
  logic   rsv_valid_q, rsv_valid_d;
  logic   done, slot_free;
  logic   unused_taps;

  assign unused_taps = ^cur_ark2sb4_val;
  assign rnd         = RND_INIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      rsv_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsv_valid_q <= rsv_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rsv_valid_d = rsv_valid_q;
    init        = 1'b0;
    compute     = 1'b0;
    add_track   = 1'b0;
    sub_track   = 1'b0;
    do_load     = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_id      = '0;
    done        = 1'b0;
    slot_free   = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        init        = 1'b1;
        rsv_valid_d = 1'b0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        compute   = 1'b1;
        done      = is_live_id(cur_mc2ark4_val) && (cur_mc2ark3_val == LAST_RND);
        slot_free = (cur_mc2ark4_val == EMPTY_ID) || done;
        if (flush) begin
          state_d     = ST_INIT;
          rsv_valid_d = 1'b0;
        end else begin
          sub_track = done;
          out_valid = done;
          out_id    = done ? cur_mc2ark4_val : '0;
          add_track = in_valid && !rsv_valid_q && track_avlbl && !done;
          do_load   = in_valid && rsv_valid_q && slot_free;
          in_ready  = do_load;
          if (add_track)
            rsv_valid_d = 1'b1;
          else if (do_load)
            rsv_valid_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Gated by RUN so busy reads 0 while held in reset/INIT regardless of the datapath status.
  assign busy = (state_q == ST_RUN) && (rsv_valid_q || !cmplt_sts);

`ifdef PIPE_CTRL_STATS_EN
  logic stats_clr, stall_inc;

  assign stats_clr = (state_q == ST_INIT);
  assign stall_inc = (state_q == ST_RUN) && in_valid && !in_ready;

  pipe_ctrl_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (stats_clr),
    .blk_inc  (out_valid),
    .stall_inc(stall_inc),
    .blk_cnt  (blk_cnt),
    .stall_cnt(stall_cnt)
  );
`else
  assign blk_cnt   = '0;
  assign stall_cnt = '0;
`endif

  a_load_add_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_load && add_track));
  a_out_id_qual: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid == (out_id != 4'd0));

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Param RND_INIT, default 4'd1: round value loaded with each new block.
REQ-002 Param LAST_RND, default 4'd10: round value at which a block completes.
REQ-003 Param CNT_W, default 16: statistics counter width.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  abort all in-flight blocks and re-initialise the pipeline.
REQ-007 in_valid  in  1  user has a plaintext/key pair on the datapath inputs.
REQ-008 in_ready  out  1  pair accepted this cycle (transfer = in_valid & in_ready).
REQ-009 out_valid  out  1  cipher_text is valid this cycle; no backpressure.
REQ-010 out_id  out  4  pair id of the completing block (1..4), 0 when out_valid=0.
REQ-011 busy  out  1  any slot allocated or reservation pending.
REQ-012 track_avlbl, cmplt_sts  in  1 each  datapath slot status.
REQ-013 cur_mc2ark3_val, cur_mc2ark4_val, cur_ark2sb4_val  in  4 each  datapath round/id taps.
REQ-014 compute, do_load, init, add_track, sub_track  out  1 each  datapath controls.
REQ-015 rnd  out  4  round value for loading; constant RND_INIT.
REQ-016 blk_cnt, stall_cnt  out  CNT_W each  statistics (see Configuration).

Function
REQ-017 The FSM SHALL have states INIT and RUN; INIT -> RUN unconditionally after one cycle; RUN -> INIT when flush=1.
REQ-018 In INIT: init=1, compute=0, all other control and handshake outputs 0.
REQ-019 In RUN: compute=1 every cycle.
REQ-020 done = RUN & cur_mc2ark4_val in 1..4 & cur_mc2ark3_val==LAST_RND; id 4'hF (bubble) SHALL never complete.
REQ-021 On done: sub_track=1, out_valid=1, out_id=cur_mc2ark4_val, same cycle.
REQ-022 Reservation: add_track=1 when RUN & in_valid & !rsv_valid & track_avlbl & !done; rsv_valid set next edge.
REQ-023 slot_free = (cur_mc2ark4_val==4'hF) | done.
REQ-024 Load: in_ready=do_load=1 when RUN & rsv_valid & in_valid & slot_free; rsv_valid clears next edge.
REQ-025 Minimum in_valid-to-in_ready latency: 1 cycle (add_track cycle, then load).
REQ-026 Acceptance-to-out_valid latency: exactly 4*(LAST_RND-RND_INIT+1) cycles (40 at defaults), regardless of other traffic.
REQ-027 A reservation survives in_valid deasserting; the held id is used on the next transfer.
REQ-028 track_avlbl=0 (4 blocks in flight): in_ready stays 0 until a done frees a slot.
REQ-029 flush=1 in RUN suppresses in_ready, do_load, add_track, sub_track, out_valid that cycle; in-flight blocks are discarded.
REQ-030 busy = rsv_valid | !cmplt_sts.

Reset
REQ-031 While rst_n=0: state=INIT, rsv_valid=0, init=1, all other outputs 0, counters 0.
REQ-032 After rst_n release: one INIT cycle (init=1), then RUN.

Configuration
REQ-033 Macro PIPE_CTRL_STATS_EN: when defined, blk_cnt increments on each out_valid and stall_cnt on each cycle with in_valid & !in_ready in RUN, both saturating at all-ones and cleared in INIT.
REQ-034 Without PIPE_CTRL_STATS_EN, blk_cnt and stall_cnt are tied to 0 and no counter flops exist.

Structure
REQ-035 Package pipe_ctrl_pkg: state enum, EMPTY_ID=4'hF, MAX_ID=4'd4, default RND_INIT/LAST_RND.
REQ-036 Sub-module pipe_ctrl_stats holds both saturating counters; instantiated only under PIPE_CTRL_STATS_EN.

Verification
REQ-037 Reset release -> exactly one cycle init=1, then compute=1, in_ready=0, busy=0.
REQ-038 Single FIPS-197 vector accepted at cycle t -> out_valid at t+40, out_id=1, cipher_text 3925841d02dc09fbdc118597196a0b32.
REQ-039 Five back-to-back in_valid -> ids 1..4 accepted, 5th stalls (stall_cnt counts with macro) until id 1 completes; 5th then gets id 1.
REQ-040 Completion and load in the same cycle on one slot -> out_valid and in_ready both 1; new block emerges 40 cycles later.
REQ-041 flush at cycle 20 of a block -> no out_valid ever for it; next cycle init=1; new block completes normally.
REQ-042 in_valid pulses 1 cycle then drops -> add_track once, rsv held; later in_valid -> immediate in_ready, no second add_track.
